// File: rtl/exercise_1.sv
// 16-lamp pattern controller: a 4-bit command picks one of four animations
// and a step rate, and a small Moore FSM drives the registered lamp bank.
module exercise_1 (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [3:0]  data_in,
  output logic [15:0] lamp_ctl
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN_LEFT  = 3'd1,
    RUN_RIGHT = 3'd2,
    FLASH     = 3'd3,
    CONVERGE  = 3'd4
  } state_t;

  state_t      state_reg;
  logic [3:0]  cfg_reg;
  logic [1:0]  cnt_reg;
  logic [15:0] lamp_reg;

  state_t      load_state;
  logic [15:0] init_pattern;
  logic [15:0] step_pattern;
  logic [7:0]  conv_hi_next;
  logic [7:0]  conv_lo_next;

  // Run state and starting pattern selected by an incoming command.
  always_comb begin
    load_state   = RUN_LEFT;
    init_pattern = 16'h0001;
    case (data_in[3:2])
      2'b00: begin load_state = RUN_LEFT;  init_pattern = 16'h0001; end
      2'b01: begin load_state = RUN_RIGHT; init_pattern = 16'h8000; end
      2'b10: begin load_state = FLASH;     init_pattern = 16'hFFFF; end
      2'b11: begin load_state = CONVERGE;  init_pattern = 16'h8001; end
      default: begin load_state = IDLE;    init_pattern = 16'h0000; end
    endcase
  end

  // Converge moves each half's lit lamp toward the centre; once they meet
  // at 0180 both halves wrap back out to the edges.
  always_comb begin
    conv_hi_next = lamp_reg[8] ? 8'h80 : (lamp_reg[15:8] >> 1);
    conv_lo_next = lamp_reg[7] ? 8'h01 : (lamp_reg[7:0] << 1);
  end

  always_comb begin
    step_pattern = 16'h0000;
    case (state_reg)
      RUN_LEFT:  step_pattern = {lamp_reg[14:0], lamp_reg[15]};
      RUN_RIGHT: step_pattern = {lamp_reg[0], lamp_reg[15:1]};
      FLASH:     step_pattern = ~lamp_reg;
      CONVERGE:  step_pattern = {conv_hi_next, conv_lo_next};
      default:   step_pattern = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cfg_reg   <= 4'b0000;
      cnt_reg   <= 2'd0;
      lamp_reg  <= 16'h0000;
    end else if (load) begin
      state_reg <= load_state;
      cfg_reg   <= data_in;
      cnt_reg   <= 2'd0;
      lamp_reg  <= init_pattern;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg  <= 2'd0;
          lamp_reg <= 16'h0000;
        end
        RUN_LEFT, RUN_RIGHT, FLASH, CONVERGE: begin
          // A step lands every (rate + 1) clocks, counted from the load edge.
          if (cnt_reg == cfg_reg[1:0]) begin
            cnt_reg  <= 2'd0;
            lamp_reg <= step_pattern;
          end else begin
            cnt_reg  <= cnt_reg + 2'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cfg_reg   <= 4'b0000;
          cnt_reg   <= 2'd0;
          lamp_reg  <= 16'h0000;
        end
      endcase
    end
  end

  assign lamp_ctl = lamp_reg;

endmodule

// File: tb/tb_exercise_1.sv
// Bench for exercise_1: directed scenarios followed by random commands, each
// clock checked against a model that derives the lamp pattern from elapsed time.
module tb_exercise_1;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [3:0]  data_in;
  logic [15:0] lamp_ctl;

  int checks = 0;
  int errors = 0;

  // Model: whether a command is active, the command, and clocks since its load.
  bit         m_active = 1'b0;
  logic [3:0] m_cfg    = 4'b0000;
  int         m_since  = 0;

  exercise_1 dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data_in  (data_in),
    .lamp_ctl (lamp_ctl)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pattern_at(input logic [1:0] mode, input int k);
    logic [15:0] lsb = 16'h0001;
    logic [15:0] msb = 16'h8000;
    int j;
    case (mode)
      2'b00: pattern_at = lsb << (k % 16);
      2'b01: pattern_at = msb >> (k % 16);
      2'b10: pattern_at = ((k % 2) == 0) ? 16'hFFFF : 16'h0000;
      default: begin
        j = k % 8;
        pattern_at = (msb >> j) | (lsb << j);
      end
    endcase
  endfunction

  function automatic logic [15:0] model_expected();
    int steps;
    if (!m_active) return 16'h0000;
    steps = m_since / (int'(m_cfg[1:0]) + 1);
    return pattern_at(m_cfg[3:2], steps);
  endfunction

  task automatic cycle(input logic r, input logic l, input logic [3:0] d, input string tag);
    logic [15:0] exp;
    reset   = r;
    load    = l;
    data_in = d;
    @(posedge clk);
    #1;
    if (r) begin
      m_active = 1'b0;
      m_cfg    = 4'b0000;
      m_since  = 0;
    end else if (l) begin
      m_active = 1'b1;
      m_cfg    = d;
      m_since  = 0;
    end else if (m_active) begin
      m_since++;
    end
    exp = model_expected();
    checks++;
    assert (lamp_ctl === exp)
      else begin
        errors++;
        $error("FAIL %s: lamp_ctl=%h expected %h", tag, lamp_ctl, exp);
      end
    $display("%-10s reset=%b load=%b data_in=%b lamp_ctl=%h expected=%h",
             tag, r, l, d, lamp_ctl, exp);
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    data_in = 4'b0000;

    // Reset held, then idle with load low and noise on data_in.
    repeat (2) cycle(1'b1, 1'b0, 4'b0000, "reset");
    repeat (5) cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)), "idle");

    // Converge at full rate, one full 8-step cycle plus the wrap.
    cycle(1'b0, 1'b1, 4'b1100, "conv_load");
    repeat (8) cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)), "conv_run");

    // Left rotation at the slowest rate, long enough to see 8000 -> 0001.
    cycle(1'b0, 1'b1, 4'b0011, "left_load");
    repeat (66) cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)), "left_run");

    // Right rotation at full rate for 17 clocks.
    cycle(1'b0, 1'b1, 4'b0100, "right_load");
    repeat (17) cycle(1'b0, 1'b0, 4'b0000, "right_run");

    // Flash every 2 clocks, then load held for 3 edges before release.
    cycle(1'b0, 1'b1, 4'b1001, "flash_load");
    repeat (5) cycle(1'b0, 1'b0, 4'b0000, "flash_run");
    repeat (3) cycle(1'b0, 1'b1, 4'b1001, "flash_hold");
    repeat (5) cycle(1'b0, 1'b0, 4'b0000, "flash_rel");

    // Reset with load asserted mid-converge: reset must win.
    cycle(1'b0, 1'b1, 4'b1101, "conv2_load");
    repeat (5) cycle(1'b0, 1'b0, 4'b0000, "conv2_run");
    cycle(1'b1, 1'b1, 4'b0110, "reset_load");
    repeat (6) cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)), "post_reset");

    // Random commands, occasional mid-pattern reloads and resets.
    for (int i = 0; i < 300; i++) begin
      logic r;
      logic l;
      r = ($urandom_range(0, 39) == 0);
      l = ($urandom_range(0, 9) == 0);
      cycle(r, l, 4'($urandom_range(0, 15)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
